riscv_mc_ctrl: RTL

Multi-cycle control unit for the simple RV32I core. It sequences the shared datapath (PC, IR, register file, ALU, single data port) through fetch/decode/execute/memory/writeback states, one instruction at a time. It drives the instruction-memory and data-memory request handshakes and raises a sticky halt on ECALL, EBREAK or an illegal opcode. It sits between the IR/ALU datapath and the memory ports.

---
 rtl/riscv_mc_ctrl_pkg.sv | 90 +++++++++
 rtl/riscv_mc_ctrl_if.sv | 27 ++
 rtl/riscv_mc_ctrl_op_decode.sv | 45 ++++
 rtl/riscv_mc_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/riscv_mc_ctrl_pkg.sv
// Shared RV32I definitions for the multi-cycle controller: instruction layout,
// opcode constants, FSM/select enums and the instruction classes the decoder produces.
package riscv_mc_ctrl_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_t;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_IMM    = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    // ECALL and EBREAK share OPCODE_SYSTEM and funct3=0; only the I-immediate differs.
    localparam logic [2:0]  FUNCT3_PRIV    = 3'b000;
    localparam logic [11:0] FUNCT12_ECALL  = 12'd0;
    localparam logic [11:0] FUNCT12_EBREAK = 12'd1;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JALR   = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU   = 2'd0,
        WB_LOAD  = 2'd1,
        WB_PC4   = 2'd2,
        WB_UIMM  = 2'd3
    } wb_sel_t;

    typedef enum logic [3:0] {
        CLS_OP      = 4'd0,
        CLS_IMM     = 4'd1,
        CLS_LUI     = 4'd2,
        CLS_AUIPC   = 4'd3,
        CLS_LOAD    = 4'd4,
        CLS_STORE   = 4'd5,
        CLS_BRANCH  = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JALR    = 4'd8,
        CLS_ECALL   = 4'd9,
        CLS_EBREAK  = 4'd10,
        CLS_ILLEGAL = 4'd11
    } instr_class_t;

    function automatic logic [11:0] sys_funct12(input instruction_t instr);
        return {instr.funct7, instr.rs2};
    endfunction

    function automatic wb_sel_t wb_sel_for(input instr_class_t cls);
        case (cls)
            CLS_LOAD:          return WB_LOAD;
            CLS_JAL, CLS_JALR: return WB_PC4;
            CLS_LUI:           return WB_UIMM;
            default:           return WB_ALU;
        endcase
    endfunction

    function automatic pc_sel_t wb_pc_sel_for(input instr_class_t cls);
        case (cls)
            CLS_JAL:  return PC_BRANCH;
            CLS_JALR: return PC_JALR;
            default:  return PC_PLUS4;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_ctrl_if.sv
// Instruction- and data-memory request/ready handshakes between the controller
// (master) and the memory ports (slave).
interface riscv_mc_ctrl_if;

    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );

endinterface

// File: rtl/riscv_mc_ctrl_op_decode.sv
// Combinational opcode classifier: maps the IR contents to an instruction class
// and flags anything outside the supported RV32I subset as illegal.
module riscv_op_decode
    import riscv_mc_ctrl_pkg::*;
(
    input  instruction_t i_instr,
    output instr_class_t o_class,
    output logic         o_legal
);

    logic [11:0] w_funct12;
    logic        w_unused;

    assign w_funct12 = sys_funct12(i_instr);
    assign w_unused  = ^{i_instr.rd, i_instr.rs1};

    // SYSTEM is only legal as the exact ECALL/EBREAK encodings; CSR ops are not supported.
    always_comb begin
        o_class = CLS_ILLEGAL;
        case (i_instr.opcode)
            OPCODE_OP:     o_class = CLS_OP;
            OPCODE_IMM:    o_class = CLS_IMM;
            OPCODE_LUI:    o_class = CLS_LUI;
            OPCODE_AUIPC:  o_class = CLS_AUIPC;
            OPCODE_LOAD:   o_class = CLS_LOAD;
            OPCODE_STORE:  o_class = CLS_STORE;
            OPCODE_BRANCH: o_class = CLS_BRANCH;
            OPCODE_JAL:    o_class = CLS_JAL;
            OPCODE_JALR:   o_class = CLS_JALR;
            OPCODE_SYSTEM: begin
                if (i_instr.funct3 == FUNCT3_PRIV && w_funct12 == FUNCT12_ECALL) begin
                    o_class = CLS_ECALL;
                end else if (i_instr.funct3 == FUNCT3_PRIV && w_funct12 == FUNCT12_EBREAK) begin
                    o_class = CLS_EBREAK;
                end else begin
                    o_class = CLS_ILLEGAL;
                end
            end
            default:       o_class = CLS_ILLEGAL;
        endcase
    end

    assign o_legal = (o_class != CLS_ILLEGAL);

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the memory handshakes and datapath strobes, and halts on ECALL/EBREAK/illegal.
module riscv_mc_ctrl
    import riscv_mc_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  instruction_t           i_instr,
    input  logic                   i_branch_taken,
    riscv_mc_ctrl_if.master        mem,
    output logic                   o_ir_we,
    output logic                   o_pc_we,
    output logic                   o_rf_we,
    output logic [1:0]             o_pc_sel,
    output logic [1:0]             o_wb_sel,
    output logic                   o_alu_a_sel,
    output logic                   o_alu_b_sel,
    output logic                   o_halted,
    output logic                   o_illegal,
    output logic [2:0]             o_state
);

    ctrl_state_t  r_state;
    ctrl_state_t  w_next_state;
    logic         r_illegal;
    instr_class_t w_class;
    logic         w_legal;
    pc_sel_t      w_pc_sel;
    wb_sel_t      w_wb_sel;

    riscv_op_decode u_op_decode (
        .i_instr (i_instr),
        .o_class (w_class),
        .o_legal (w_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The illegal flag is captured on the DECODE->HALT transition and held until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (r_state == ST_DECODE && !w_legal) begin
            r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (mem.imem_ready) begin
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (w_class)
                    CLS_ECALL, CLS_EBREAK, CLS_ILLEGAL: w_next_state = ST_HALT;
                    default:                            w_next_state = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (w_class)
                    CLS_LOAD, CLS_STORE: w_next_state = ST_MEM;
                    CLS_BRANCH:          w_next_state = ST_FETCH;
                    default:             w_next_state = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem.dmem_ready) begin
                    w_next_state = (w_class == CLS_STORE) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB:   w_next_state = ST_FETCH;
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_FETCH;
        endcase
    end

    // Reset forces every output low immediately, so a held rst also withdraws open requests.
    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        o_ir_we      = 1'b0;
        o_pc_we      = 1'b0;
        o_rf_we      = 1'b0;
        w_pc_sel     = PC_PLUS4;
        w_wb_sel     = WB_ALU;
        o_alu_a_sel  = 1'b0;
        o_alu_b_sel  = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    mem.imem_req = 1'b1;
                    o_ir_we      = mem.imem_ready;
                end
                ST_EXEC: begin
                    case (w_class)
                        CLS_IMM: begin
                            o_alu_b_sel = 1'b1;
                        end
                        CLS_AUIPC: begin
                            o_alu_a_sel = 1'b1;
                            o_alu_b_sel = 1'b1;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            o_alu_b_sel = 1'b1;
                        end
                        CLS_BRANCH: begin
                            o_pc_we  = 1'b1;
                            w_pc_sel = i_branch_taken ? PC_BRANCH : PC_PLUS4;
                        end
                        default: begin
                            o_alu_a_sel = 1'b0;
                        end
                    endcase
                end
                ST_MEM: begin
                    mem.dmem_req = 1'b1;
                    mem.dmem_we  = (w_class == CLS_STORE);
                    o_pc_we      = mem.dmem_ready && (w_class == CLS_STORE);
                end
                ST_WB: begin
                    o_rf_we  = 1'b1;
                    o_pc_we  = 1'b1;
                    w_wb_sel = wb_sel_for(w_class);
                    w_pc_sel = wb_pc_sel_for(w_class);
                end
                default: begin
                    o_ir_we = 1'b0;
                end
            endcase
        end
    end

    assign o_pc_sel  = w_pc_sel;
    assign o_wb_sel  = w_wb_sel;
    assign o_halted  = !rst && (r_state == ST_HALT);
    assign o_illegal = !rst && r_illegal;
    assign o_state   = rst ? ST_FETCH : r_state;

endmodule
